mii_tx_arbiter: RTL and testbench

MII_TX_ARBITER -- requirements
Module: mii_tx_arbiter

---
 rtl/mii_tx_arbiter_if.sv | 23 ++
 rtl/mii_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_mii_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mii_tx_arbiter_if.sv
// mii_tx_arbiter_if: requester lanes, PHY-side MII transmit signals and grant status of the arbiter
interface mii_tx_arbiter_if;
    logic [3:0]  req;
    logic [3:0]  req_TX_EN;
    logic [3:0]  req_TX_ER;
    logic [15:0] req_TXD;
    logic        COL;
    logic [3:0]  grant;
    logic [3:0]  req_COL;
    logic        TX_EN;
    logic        TX_ER;
    logic [3:0]  TXD;
    logic [1:0]  cur_id;
    logic        jabber;
    modport master (
        output req, req_TX_EN, req_TX_ER, req_TXD, COL,
        input  grant, req_COL, TX_EN, TX_ER, TXD, cur_id, jabber
    );
    modport slave (
        input  req, req_TX_EN, req_TX_ER, req_TXD, COL,
        output grant, req_COL, TX_EN, TX_ER, TXD, cur_id, jabber
    );
endinterface

// File: rtl/mii_tx_arbiter.sv
// mii_tx_arbiter: round-robin sharing of one MII transmit port with grant timeout, jabber abort and IPG
module mii_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TO_TIMER    = 32,
    parameter int IPG_NIBBLES = 24,
    parameter int MAX_NIBBLES = 3072
) (
    input logic            TX_CLK,
    input logic            reset,
    mii_tx_arbiter_if.slave bus
);
    localparam int CM0  = TO_TIMER > IPG_NIBBLES ? TO_TIMER : IPG_NIBBLES;
    localparam int CMAX = CM0 > MAX_NIBBLES ? CM0 : MAX_NIBBLES;
    localparam int CW   = CMAX > 2 ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XMIT, S_IPG} state_t;

    state_t           r_state, w_next;
    logic [N_REQ-1:0] r_grant, w_grant;
    logic [1:0]       r_cur_id, w_cur_id, r_ptr, w_ptr, w_sel;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic             r_tx_en, w_tx_en, r_tx_er, w_tx_er, r_jabber, w_jabber;
    logic [3:0]       r_txd, w_txd;
    logic             w_lane_en, w_lane_er, w_lane_req, w_any, w_to, w_jab, w_ipg_done;
    logic [3:0]       w_lane_txd;

    assign w_lane_en  = bus.req_TX_EN[r_cur_id];
    assign w_lane_er  = bus.req_TX_ER[r_cur_id];
    assign w_lane_req = bus.req[r_cur_id];
    assign w_lane_txd = bus.req_TXD[{r_cur_id, 2'b00} +: 4];
    assign w_any      = |bus.req;
    assign w_to       = r_cnt == CW'(TO_TIMER - 1);
    assign w_jab      = r_cnt == CW'(MAX_NIBBLES - 1);
    assign w_ipg_done = r_cnt == CW'(IPG_NIBBLES - 1);

    assign bus.grant   = r_grant;
    assign bus.req_COL = {N_REQ{bus.COL}} & r_grant;
    assign bus.TX_EN   = r_tx_en;
    assign bus.TX_ER   = r_tx_er;
    assign bus.TXD     = r_txd;
    assign bus.cur_id  = r_cur_id;
    assign bus.jabber  = r_jabber;

    // first requester at or above the rotating pointer, wrapping past the top lane
    always_comb begin
        w_sel = r_ptr;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (bus.req[r_ptr + 2'(i)]) w_sel = r_ptr + 2'(i);
    end

    // state register
    always_ff @(posedge TX_CLK or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state: TX_EN of the granted lane outranks a dropped request or timeout while waiting
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_any ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = w_lane_en ? S_XMIT : (!w_lane_req || w_to) ? S_IDLE : S_WAIT;
            S_XMIT:  w_next = (!w_lane_en || w_jab) ? S_IPG : S_XMIT;
            default: w_next = w_ipg_done ? S_IDLE : S_IPG;
        endcase
    end

    // next register values: one shared counter serves as grant timer, nibble count and gap count
    always_comb begin
        w_grant  = r_grant;
        w_cur_id = r_cur_id;
        w_ptr    = r_ptr;
        w_cnt    = r_cnt;
        w_tx_en  = 1'b0;
        w_tx_er  = 1'b0;
        w_txd    = 4'd0;
        w_jabber = 1'b0;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_grant  = N_REQ'(1) << w_sel;
                w_cur_id = w_sel;
                w_cnt    = '0;
            end
            S_WAIT: if (w_lane_en) begin
                w_tx_en = 1'b1;
                w_tx_er = w_lane_er;
                w_txd   = w_lane_txd;
                w_cnt   = '0;
            end else if (!w_lane_req || w_to) begin
                w_grant = '0;
                w_ptr   = r_cur_id + 2'd1;
                w_cnt   = '0;
            end else begin
                w_cnt = r_cnt + 1'b1;
            end
            S_XMIT: if (!w_lane_en || w_jab) begin
                w_grant  = '0;
                w_ptr    = r_cur_id + 2'd1;
                w_cnt    = '0;
                w_tx_er  = w_lane_en;
                w_jabber = w_lane_en;
            end else begin
                w_tx_en = 1'b1;
                w_tx_er = w_lane_er;
                w_txd   = w_lane_txd;
                w_cnt   = r_cnt + 1'b1;
            end
            default: w_cnt = w_ipg_done ? '0 : r_cnt + 1'b1;
        endcase
    end

    // datapath and output registers
    always_ff @(posedge TX_CLK or posedge reset) begin
        if (reset) begin
            r_grant  <= '0;
            r_cur_id <= 2'd0;
            r_ptr    <= 2'd0;
            r_cnt    <= '0;
            r_tx_en  <= 1'b0;
            r_tx_er  <= 1'b0;
            r_txd    <= 4'd0;
            r_jabber <= 1'b0;
        end else begin
            r_grant  <= w_grant;
            r_cur_id <= w_cur_id;
            r_ptr    <= w_ptr;
            r_cnt    <= w_cnt;
            r_tx_en  <= w_tx_en;
            r_tx_er  <= w_tx_er;
            r_txd    <= w_txd;
            r_jabber <= w_jabber;
        end
    end
endmodule

// File: tb/tb_mii_tx_arbiter.sv
// tb_mii_tx_arbiter: randomized frames on a shared MII port checked against a round-robin frame model
module tb_mii_tx_arbiter;
    localparam int TO_TIMER    = 32;
    localparam int IPG_NIBBLES = 24;
    localparam int MAX_NIBBLES = 3072;

    logic TX_CLK = 1'b0;
    logic reset  = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    int   m_ptr  = 0;
    int   lane   = 0;

    mii_tx_arbiter_if bus();

    mii_tx_arbiter dut (
        .TX_CLK (TX_CLK),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 TX_CLK = ~TX_CLK;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic int pick(input logic [3:0] m, input int p);
        for (int i = 0; i < 4; i++)
            if (m[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    task automatic tick;
        @(posedge TX_CLK);
        #1;
    endtask

    task automatic drive_noise(input int k);
        bus.req_TX_EN = 4'($urandom) & ~(4'b1 << k);
        bus.req_TX_ER = 4'($urandom);
        bus.req_TXD   = 16'($urandom);
    endtask

    task automatic send_frame(input int k, input int len, input int dly, input bit col,
                              input logic [3:0] nmask, output int nk);
        logic [3:0] nib;
        logic       er;
        int         n;
        bit         leak;
        bus.COL = 1'b0;
        for (int d = 0; d < dly; d++) begin
            drive_noise(k);
            tick;
            total++;
            if ({bus.grant, bus.TX_EN} !== {4'(1 << k), 1'b0}) begin
                bad++;
                $display("FAIL wait_hold lane=%0d got grant=%b tx_en=%b", k, bus.grant, bus.TX_EN);
            end
        end
        for (int j = 0; j < len; j++) begin
            bus.req_TX_EN = 4'($urandom) | (4'b1 << k);
            bus.req_TX_ER = 4'($urandom);
            bus.req_TXD   = 16'($urandom);
            bus.req       = 4'($urandom);
            bus.COL       = col;
            nib = bus.req_TXD[4*k +: 4];
            er  = bus.req_TX_ER[k];
            tick;
            total++;
            if ({bus.TX_EN, bus.TX_ER, bus.TXD} !== {1'b1, er, nib}) begin
                bad++;
                $display("FAIL nibble lane=%0d idx=%0d got en/er/txd=%b/%b/%h exp 1/%b/%h",
                         k, j, bus.TX_EN, bus.TX_ER, bus.TXD, er, nib);
            end
            total++;
            if ({bus.grant, bus.req_COL} !== {4'(1 << k), col ? 4'(1 << k) : 4'b0}) begin
                bad++;
                $display("FAIL grant_col lane=%0d got grant=%b req_col=%b col=%b", k, bus.grant, bus.req_COL, col);
            end
        end
        drive_noise(k);
        bus.req = nmask;
        bus.COL = 1'b0;
        tick;
        total++;
        if ({bus.grant, bus.TX_EN, bus.TX_ER, bus.TXD, bus.jabber} !== 11'd0) begin
            bad++;
            $display("FAIL frame_end lane=%0d got grant=%b en=%b er=%b txd=%h jab=%b",
                     k, bus.grant, bus.TX_EN, bus.TX_ER, bus.TXD, bus.jabber);
        end
        m_ptr = (k + 1) % 4;
        nk    = pick(nmask, m_ptr);
        n     = 0;
        leak  = 0;
        while (bus.grant === 4'b0 && n < 200) begin
            drive_noise(4);
            tick;
            n++;
            if (bus.TX_EN !== 1'b0) leak = 1;
        end
        total++;
        if (leak) begin
            bad++;
            $display("FAIL ipg_quiet got TX_EN high during gap exp low");
        end
        total++;
        if (n != IPG_NIBBLES + 1) begin
            bad++;
            $display("FAIL ipg_len got=%0d exp=%0d", n, IPG_NIBBLES + 1);
        end
        total++;
        if (bus.grant !== 4'(1 << nk) || bus.cur_id !== 2'(nk)) begin
            bad++;
            $display("FAIL next_grant got=%b id=%0d exp lane %0d", bus.grant, bus.cur_id, nk);
        end
    endtask

    task automatic test_reset;
        bus.req = 4'b0; bus.req_TX_EN = 4'b0; bus.req_TX_ER = 4'b0; bus.req_TXD = 16'b0; bus.COL = 1'b0;
        reset = 1'b1;
        repeat (3) tick;
        total++;
        if ({bus.grant, bus.TX_EN, bus.TX_ER, bus.TXD, bus.cur_id, bus.jabber, bus.req_COL} !== 17'd0) begin
            bad++;
            $display("FAIL reset_state got grant=%b en=%b er=%b txd=%h id=%0d jab=%b exp all 0",
                     bus.grant, bus.TX_EN, bus.TX_ER, bus.TXD, bus.cur_id, bus.jabber);
        end
        bus.req = 4'b0101;
        reset   = 1'b0;
        #2;
        total++;
        if (bus.grant !== 4'b0) begin
            bad++;
            $display("FAIL early_grant got=%b exp=0000", bus.grant);
        end
        @(posedge TX_CLK);
        #1;
        m_ptr = 0;
        lane  = pick(4'b0101, m_ptr);
        total++;
        if (bus.grant !== 4'(1 << lane) || bus.cur_id !== 2'(lane)) begin
            bad++;
            $display("FAIL first_grant got=%b id=%0d exp lane %0d", bus.grant, bus.cur_id, lane);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] m;
        send_frame(lane, 8, 0, 1'b0, 4'b0101, lane);
        for (int it = 0; it < 8; it++) begin
            m = (it == 7) ? 4'b0010 : 4'($urandom_range(1, 15));
            send_frame(lane, $urandom_range(1, 16), $urandom_range(0, 5), 1'b0, m, lane);
        end
    endtask

    task automatic test_timeout;
        int n;
        bit leak;
        n    = 1;
        leak = 0;
        bus.req = 4'b0010;
        while (bus.grant === 4'b0010 && n < 100) begin
            drive_noise(1);
            tick;
            if (bus.TX_EN !== 1'b0) leak = 1;
            if (bus.grant === 4'b0010) n++;
        end
        total++;
        if (n != TO_TIMER || leak) begin
            bad++;
            $display("FAIL timeout got grant_cycles=%0d leak=%b exp %0d no leak", n, leak, TO_TIMER);
        end
        m_ptr   = 2;
        bus.req = 4'b1111;
        tick;
        lane = pick(4'b1111, m_ptr);
        total++;
        if (bus.grant !== 4'(1 << lane)) begin
            bad++;
            $display("FAIL timeout_ptr got=%b exp lane %0d", bus.grant, lane);
        end
    endtask

    task automatic test_jabber;
        int hi, drv, n;
        hi  = 0;
        drv = 0;
        bus.req = 4'b1111;
        do begin
            bus.req_TX_EN = 4'b0100;
            bus.req_TX_ER = 4'b0;
            bus.req_TXD   = 16'($urandom);
            tick;
            drv++;
            if (bus.TX_EN === 1'b1) hi++;
        end while ((bus.TX_EN === 1'b1 || hi == 0) && drv < 3200);
        total++;
        if (hi != MAX_NIBBLES) begin
            bad++;
            $display("FAIL jabber_len got=%0d exp=%0d", hi, MAX_NIBBLES);
        end
        total++;
        if ({bus.TX_EN, bus.TX_ER, bus.jabber, bus.grant} !== 7'b0110000) begin
            bad++;
            $display("FAIL jabber_abort got en=%b er=%b jab=%b grant=%b exp 0/1/1/0000",
                     bus.TX_EN, bus.TX_ER, bus.jabber, bus.grant);
        end
        m_ptr = 3;
        n     = 0;
        while (bus.grant === 4'b0 && n < 200) begin
            bus.req_TX_EN = (drv < 3100) ? 4'b0100 : 4'b0;
            tick;
            drv++;
            n++;
            if (n == 1) begin
                total++;
                if ({bus.TX_ER, bus.jabber, bus.TX_EN} !== 3'b0) begin
                    bad++;
                    $display("FAIL jabber_pulse got er=%b jab=%b en=%b exp 0/0/0", bus.TX_ER, bus.jabber, bus.TX_EN);
                end
            end
        end
        lane = pick(4'b1111, m_ptr);
        total++;
        if (n != IPG_NIBBLES + 1 || bus.grant !== 4'(1 << lane)) begin
            bad++;
            $display("FAIL jabber_ipg got gap=%0d grant=%b exp %0d lane %0d", n, bus.grant, IPG_NIBBLES + 1, lane);
        end
    endtask

    task automatic test_collision;
        send_frame(lane, 10, 2, 1'b1, 4'b0010, lane);
    endtask

    task automatic test_reset_mid_xmit;
        for (int j = 0; j < 3; j++) begin
            bus.req_TX_EN = 4'b1 << lane;
            bus.req_TXD   = 16'($urandom);
            tick;
        end
        total++;
        if (bus.TX_EN !== 1'b1 || bus.cur_id !== 2'(lane)) begin
            bad++;
            $display("FAIL pre_reset got en=%b id=%0d exp 1 lane %0d", bus.TX_EN, bus.cur_id, lane);
        end
        bus.COL = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.grant, bus.TX_EN, bus.TX_ER, bus.TXD, bus.cur_id, bus.jabber, bus.req_COL} !== 17'd0) begin
            bad++;
            $display("FAIL async_reset got grant=%b en=%b er=%b txd=%h id=%0d jab=%b col=%b exp all 0",
                     bus.grant, bus.TX_EN, bus.TX_ER, bus.TXD, bus.cur_id, bus.jabber, bus.req_COL);
        end
        repeat (2) tick;
        bus.COL = 1'b0;
        bus.req = 4'b1111;
        reset   = 1'b0;
        tick;
        m_ptr = 0;
        lane  = pick(4'b1111, m_ptr);
        total++;
        if (bus.grant !== 4'(1 << lane) || bus.cur_id !== 2'(lane)) begin
            bad++;
            $display("FAIL post_reset_grant got=%b id=%0d exp lane %0d", bus.grant, bus.cur_id, lane);
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_timeout;
        test_jabber;
        test_collision;
        test_reset_mid_xmit;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
